fir_avg_outbuf: RTL and testbench
=================================

# fir_avg_outbuf

Output stage placed directly downstream of the 4-tap averaging FIR. It takes the FIR's (w+2)-bit running sum of the 4 most recent samples and converts it to a w-bit average by divide-by-4 with round-half-up. It discards the warm-up sums that still contain reset zeros and buffers results in a small show-ahead FIFO. The consumer reads through a valid/ready handshake; overflow is flagged, never silent.

## Interface
- `w`, 16: sample width; input sum is w+2 bits, output average is w bits.
- `WARMUP`, 3: number of valid input sums discarded after reset (sums that include reset-zero taps).
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sum_in`  in  w+2  unsigned sum from FIR output register.
- `in_valid`  in  1  `sum_in` holds a new sum this cycle; no backpressure upstream.
- `out_data`  out  w  head-of-FIFO average.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts head when `out_valid & out_ready`.
- `level`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `ovf`  out  1  sticky: a post-warm-up sum was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear of `ovf`.

## Operation
- **Rounding:** avg = (sum_in + 2) >> 2, computed at w+3 bits and truncated to w bits.
  - Max sum 2^(w+2)−4 gives 2^w−1, so the result never overflows and no saturation is needed.
- **Warm-up counter:**
  - Counts `in_valid` cycles from reset, saturating at WARMUP.
  - While count < WARMUP, a valid sum is discarded and only increments the count.
  - Once count == WARMUP, every valid sum is a push.
- **FIFO:** show-ahead, DEPTH entries, read/write pointers one bit wider than the address; full/empty derived from the pointers.
  - pop = out_valid & out_ready.
  - push = in_valid & warm-up done & (not full, or pop this cycle).
  - Push and pop in the same cycle: both occur, level unchanged. When full, the pop frees the slot and the push is accepted.
  - Push while full with no pop: sample dropped, FIFO contents unchanged, `ovf` set.
  - Pop when empty cannot occur, because out_valid = 0.
- **`ovf`:**
  - Set on a drop; cleared by `ovf_clr`.
  - Drop and `ovf_clr` in the same cycle: set wins.
- **Reset (async, any time incl. mid-stream):**
  - Pointers, level and warm-up count go to 0; `ovf` goes to 0.
  - `out_valid` goes to 0 and `out_data` goes to 0.
  - Warm-up restarts.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `level`=0, `ovf`=0.
- Latency: a push at the clk edge ending cycle n gives `out_valid`=1 with that avg in cycle n+1, provided the FIFO was empty.
- `out_data` and `out_valid` are stable while out_valid=1 and out_ready=0.
- Throughput: one push and one pop per cycle sustained; level stays constant.
- `level` and `ovf` update at the same edge as the push/pop/drop that causes them.
- `out_data` of an empty FIFO holds its last value (0 after reset); it is don't-care when out_valid=0.

## Test plan (w=16, WARMUP=3, DEPTH=4)
- **Warm-up:** after reset, 5 valid sums 100, 200, 400, 402, 406 with out_ready=1 → first three dropped; out_data 101 then 102 (402+2=404>>2=101; 408>>2=102), one cycle after each push.
- **Rounding corners:** sums 0, 1, 2, 3, 5, 6, 0x3FFFC → avg 0, 0, 1, 1, 1, 2, 0xFFFF.
- **Fill and overflow:** out_ready=0, 6 post-warm-up sums 4·k (k=1..6) → level=4, out_data=1, ovf=1 after the 5th sum, 5 and 6 lost. Then out_ready=1 → reads 1, 2, 3, 4 and out_valid falls. Then ovf_clr → ovf=0.
- **Full with simultaneous push/pop:** FIFO full (level 4), out_ready=1 and in_valid=1 with sum 40 in the same cycle → ovf stays 0, level stays 4, 10 appears as the last of the next 4 reads.
- **Backpressure stability:** toggle out_ready randomly against continuous input at level <DEPTH → consumed sequence equals input order, no duplicates or losses, out_data stable while stalled.
- **Reset mid-operation:** assert reset with level=3 and ovf=1 → same cycle, outputs read 0/0/0/0 asynchronously. After release, the next 3 valid sums are discarded again.

Source files
------------

// File: rtl/fir_avg_outbuf.sv
// fir_avg_outbuf: rounds FIR 4-tap sums to w-bit averages, skips warm-up sums, buffers them in a show-ahead FIFO
module fir_avg_outbuf #(
  parameter int w      = 16,
  parameter int WARMUP = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [w+1:0]             sum_in,
  input  logic                     in_valid,
  output logic [w-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WARMUP + 2);
  logic [AW:0]    wr, rd;
  logic [w-1:0]   mem [DEPTH];
  logic [w-1:0]   hold;
  logic [WW-1:0]  wcnt;
  logic [w+2:0]   rsum;
  logic           warm, full, pop, take, push, drop;
  always_comb begin
    rsum      = {1'b0, sum_in} + (w+3)'(2);
    warm      = wcnt == WW'(WARMUP);
    full      = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    out_valid = wr != rd;
    pop       = out_valid & out_ready;
    take      = in_valid & warm;
    push      = take & (~full | pop);
    drop      = take & full & ~pop;
    level     = wr - rd;
    out_data  = out_valid ? mem[rd[AW-1:0]] : hold;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr   <= '0;
      rd   <= '0;
      wcnt <= '0;
      ovf  <= 1'b0;
      hold <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      if (pop) hold <= mem[rd[AW-1:0]];
      if (in_valid && !warm) wcnt <= wcnt + 1'b1;
      ovf <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf;
    end
  // Storage needs no reset: it is only observed while out_valid is high.
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= rsum[w+1:2];
endmodule

// File: tb/tb_fir_avg_outbuf.sv
// tb_fir_avg_outbuf: scoreboard bench for fir_avg_outbuf (w=16, WARMUP=3, DEPTH=4)
module tb_fir_avg_outbuf;
  logic        clk = 0, reset = 1;
  logic [17:0] sum_in = '0;
  logic        in_valid = 0, out_ready = 0, ovf_clr = 0;
  logic [15:0] out_data;
  logic        out_valid, ovf;
  logic [2:0]  level;
  int checks = 0, errors = 0;
  int q[$];
  int mw = 0;
  bit movf = 0, stall = 0;
  logic [15:0] held = '0;
  fir_avg_outbuf #(.w(16), .WARMUP(3), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int avgf(input int s);
    return (s + 2) >> 2;
  endfunction
  task automatic step(input bit iv, input int s, input bit rdy, input bit clr);
    bit mfull, mpop, take;
    @(negedge clk);
    in_valid = iv; sum_in = 18'(s); out_ready = rdy; ovf_clr = clr;
    #1;
    chk("valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (stall) chk("stable", {16'b0, out_data}, {16'b0, held});
    stall = out_valid && !rdy;
    held = out_data;
    mfull = q.size() == 4;
    mpop = q.size() > 0 && rdy;
    take = iv && mw == 3;
    if (mpop) chk("data", {16'b0, out_data}, q.pop_front());
    if (take && (!mfull || mpop)) q.push_back(avgf(s));
    if (iv && mw < 3) mw++;
    movf = (take && mfull && !mpop) ? 1'b1 : clr ? 1'b0 : movf;
    @(posedge clk);
    #1;
    chk("level", {29'b0, level}, q.size());
    chk("ovf", {31'b0, ovf}, {31'b0, movf});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask
  int rnd[7] = '{0, 1, 2, 3, 5, 6, 18'h3FFFC};
  int rexp[7] = '{0, 0, 1, 1, 1, 2, 16'hFFFF};
  initial begin
    #12;
    chk("rst_data", {16'b0, out_data}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_level", {29'b0, level}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    @(negedge clk); reset = 0;
    // warm-up: 100,200,400 discarded, then 101 and 102
    step(1, 100, 1, 0); step(1, 200, 1, 0); step(1, 400, 1, 0);
    step(1, 402, 1, 0);
    chk("wu_101", {16'b0, out_data}, 101);
    step(1, 406, 1, 0);
    chk("wu_102", {16'b0, out_data}, 102);
    idle(2);
    // rounding corners with direct constant expectations
    for (int i = 0; i < 7; i++) begin
      step(1, rnd[i], 1, 0);
      chk("round", {16'b0, out_data}, rexp[i]);
    end
    idle(2);
    // fill and overflow
    for (int k = 1; k <= 6; k++) step(1, 4 * k, 0, 0);
    chk("fill_level", {29'b0, level}, 4);
    chk("fill_head", {16'b0, out_data}, 1);
    chk("fill_ovf", {31'b0, ovf}, 1);
    idle(5);
    step(0, 0, 1, 1);
    chk("ovf_clr", {31'b0, ovf}, 0);
    // full with simultaneous push and pop
    for (int k = 1; k <= 4; k++) step(1, 4 * k, 0, 0);
    step(1, 40, 1, 0);
    chk("fp_level", {29'b0, level}, 4);
    chk("fp_ovf", {31'b0, ovf}, 0);
    idle(5);
    // random backpressure
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 18'h3FFFF)), $urandom_range(0, 3) != 0, 0);
    idle(6);
    // reset mid-operation with level 3 and ovf set
    for (int k = 1; k <= 5; k++) step(1, 8 * k, 0, 0);
    step(0, 0, 1, 0);
    chk("pre_level", {29'b0, level}, 3);
    chk("pre_ovf", {31'b0, ovf}, 1);
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("mr_data", {16'b0, out_data}, 0);
    chk("mr_valid", {31'b0, out_valid}, 0);
    chk("mr_level", {29'b0, level}, 0);
    chk("mr_ovf", {31'b0, ovf}, 0);
    q.delete(); mw = 0; movf = 0; stall = 0;
    @(negedge clk); reset = 0;
    step(1, 1000, 1, 0); step(1, 2000, 1, 0); step(1, 3000, 1, 0);
    chk("mr_disc", {31'b0, out_valid}, 0);
    step(1, 4000, 1, 0);
    chk("mr_first", {16'b0, out_data}, 1000);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
